// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - data RAM request/grant/rvalid bus between the load/store unit and memory
interface dmem_lsu_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - ex_mem load/store to single word-aligned bus access; DMEM_MISALIGN_CHK_EN enables misalign abort
`ifndef INST_TYPE_L
`define INST_TYPE_L 7'b0000011
`endif
`ifndef INST_TYPE_S
`define INST_TYPE_S 7'b0100011
`endif

module dmem_lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid_i,
  input  logic        flush_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] st_data_i,
  dmem_lsu_if.master  bus,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [6:0]    opcode;
  logic [1:0]    size;
  logic [1:0]    a;
  logic          is_ld;
  logic          is_st;
  logic          start;
  logic          misalign;
  logic          timeout;
  logic          abort;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [29:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          load_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          unused_inst;

  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

  always_comb begin
    opcode = inst_i[6:0];
    size   = inst_i[13:12];
    a      = mem_addr_i[1:0];
    is_ld  = (opcode == `INST_TYPE_L);
    is_st  = (opcode == `INST_TYPE_S);
    start  = req_valid_i & (is_ld | is_st) & ~flush_i;
    // funct3[2] only selects sign extension, which the mem stage handles
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << a;
        wdata_c = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_c    = a[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_data_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = st_data_i;
      end
    endcase
`ifdef DMEM_MISALIGN_CHK_EN
    misalign = ((size == 2'b01) & a[0]) | ((size == 2'b10) & (a != 2'b00));
`else
    misalign = 1'b0;
`endif
    timeout = ((state == S_REQ) | (state == S_WAIT)) & (cnt_q >= CNT_LAST);
    // a grant or read return in the final cycle still completes normally
    abort   = timeout
            & ~((state == S_REQ) & (bus.bus_gnt_i | flush_i))
            & ~((state == S_WAIT) & bus.bus_rvalid_i);
  end

  always_ff @(posedge clk) begin
    if (rstn) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = misalign ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus.bus_gnt_i)  state_nxt = load_q ? S_WAIT : S_DONE;
        else if (flush_i)   state_nxt = S_IDLE;
        else if (abort)     state_nxt = S_DONE;
      end
      S_WAIT: if (bus.bus_rvalid_i | abort) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req_o   = (state == S_REQ);
    bus.bus_we_o    = (state == S_REQ) & ~load_q;
    bus.bus_addr_o  = {addr_q, 2'b00};
    bus.bus_be_o    = be_q;
    bus.bus_wdata_o = wdata_q;
    stall_o         = (state == S_REQ) | (state == S_WAIT) | ((state == S_IDLE) & start);
    done_o          = (state == S_DONE);
    err_o           = (state == S_DONE) & err_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_o <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        addr_q  <= mem_addr_i[31:2];
        be_q    <= be_c;
        wdata_q <= wdata_c;
        load_q  <= is_ld;
        err_q   <= misalign;
        cnt_q   <= '0;
      end else if ((state == S_REQ) || (state == S_WAIT)) begin
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        err_q <= abort;
      end
      if ((state == S_WAIT) && bus.bus_rvalid_i) rdata_o <= bus.bus_rdata_i;
      else if (abort && load_q)                 rdata_o <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu against a transaction-level model
module tb_dmem_lsu;
  localparam int T = 8;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdat;
    int          gd;
    int          rd;
  } op_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid_i;
  logic        flush_i;
  logic [31:0] inst_i;
  logic [31:0] mem_addr_i;
  logic [31:0] st_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] exp_rdata;
  int          n_chk = 0;
  int          n_pass = 0;

  dmem_lsu_if bus ();

  dmem_lsu #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid_i), .flush_i(flush_i),
    .inst_i(inst_i), .mem_addr_i(mem_addr_i), .st_data_i(st_data_i), .bus(bus),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(logic [6:0] op, logic [2:0] f3, logic [31:0] addr, logic [31:0] sd,
                             logic [31:0] rdat, int gd, int rd);
    op_t o;
    o.op = op; o.f3 = f3; o.addr = addr; o.sd = sd; o.rdat = rdat; o.gd = gd; o.rd = rd;
    return o;
  endfunction

  // Acts as the memory: grants after o.gd REQ cycles, returns data after o.rd WAIT cycles.
  task automatic run_op(input op_t o, output int stalls, output int reqs, output logic [31:0] q_addr,
                        output logic [3:0] q_be, output logic [31:0] q_wdata, output logic q_we,
                        output logic got_done, output logic got_err, output logic [31:0] q_rdata,
                        output logic req_in_done);
    int rq;
    int wt;
    logic granted;
    rq = 0; wt = 0; granted = 1'b0; stalls = 0; reqs = 0;
    q_addr = '0; q_be = '0; q_wdata = '0; q_we = 1'b0;
    got_done = 1'b0; got_err = 1'b0; q_rdata = '0; req_in_done = 1'b0;
    inst_i = {17'd0, o.f3, 5'd0, o.op}; mem_addr_i = o.addr; st_data_i = o.sd; req_valid_i = 1'b1;
    for (int c = 0; c < 40 && !got_done; c++) begin
      #1;
      bus.bus_gnt_i = 1'b0;
      bus.bus_rvalid_i = 1'($urandom_range(0, 1));
      bus.bus_rdata_i = $urandom();
      if (stall_o) stalls++;
      if (done_o) begin
        got_done = 1'b1; got_err = err_o; q_rdata = rdata_o; req_in_done = bus.bus_req_o;
        req_valid_i = 1'b0;
      end else if (bus.bus_req_o) begin
        if (reqs == 0) begin
          q_addr = bus.bus_addr_o; q_be = bus.bus_be_o; q_wdata = bus.bus_wdata_o; q_we = bus.bus_we_o;
        end
        reqs++;
        if (rq == o.gd) begin
          bus.bus_gnt_i = 1'b1;
          granted = 1'b1;
        end
        rq++;
      end else if (granted) begin
        bus.bus_rvalid_i = (wt == o.rd);
        if (wt == o.rd) bus.bus_rdata_i = o.rdat;
        wt++;
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0; bus.bus_gnt_i = 1'b0; bus.bus_rvalid_i = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (bus.bus_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", bus.bus_req_o); else n_pass++;
    n_chk++; if (bus.bus_we_o !== 1'b0) $display("FAIL reset_we got %b want 0", bus.bus_we_o); else n_pass++;
    n_chk++; if (bus.bus_addr_o !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.bus_addr_o); else n_pass++;
    n_chk++; if (bus.bus_be_o !== 4'h0) $display("FAIL reset_be got %h want 0", bus.bus_be_o); else n_pass++;
    n_chk++; if (bus.bus_wdata_o !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus.bus_wdata_o); else n_pass++;
    n_chk++; if ({stall_o, done_o, err_o} !== 3'b000) $display("FAIL reset_flags got %b want 000", {stall_o, done_o, err_o}); else n_pass++;
    n_chk++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata_o); else n_pass++;
    rstn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_non_mem;
    inst_i = {25'd0, OP_ALU}; req_valid_i = 1'b1;
    #1;
    n_chk++; if (stall_o !== 1'b0) $display("FAIL nonmem_stall got %b want 0", stall_o); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({bus.bus_req_o, done_o} !== 2'b00) $display("FAIL nonmem_idle got %b want 00", {bus.bus_req_o, done_o}); else n_pass++;
    inst_i = {25'd0, OP_L}; req_valid_i = 1'b0;
    #1;
    n_chk++; if (stall_o !== 1'b0) $display("FAIL noreq_stall got %b want 0", stall_o); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_accesses;
    op_t ops[$];
    op_t o;
    int stalls, reqs, nb, base, g, r, lim, e_req, e_st;
    logic [31:0] q_addr, q_wdata, q_rdata, e_wd;
    logic [3:0] q_be, e_be;
    logic q_we, got_done, got_err, req_in_done, is_ld, mis, e_err;
    logic [2:0] lf3[5];
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    ops.push_back(mk(OP_S, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0));
    ops.push_back(mk(OP_S, 3'd0, 32'h203, 32'h000000A5, 32'h0, 0, 0));
    ops.push_back(mk(OP_L, 3'd2, 32'h40, 32'h0, 32'h12345678, 2, 2));
    ops.push_back(mk(OP_L, 3'd1, 32'h41, 32'h0, 32'h0BADF00D, 0, 0));
    ops.push_back(mk(OP_L, 3'd2, 32'h44, 32'h0, 32'h11112222, 0, 100));
    ops.push_back(mk(OP_L, 3'd5, 32'h46, 32'h0, 32'h33334444, 1, 5));
    ops.push_back(mk(OP_L, 3'd0, 32'h47, 32'h0, 32'h55556666, 1, 6));
    ops.push_back(mk(OP_L, 3'd4, 32'h49, 32'h0, 32'h77778888, 7, 0));
    ops.push_back(mk(OP_S, 3'd1, 32'h52, 32'h0000BEEF, 32'h0, 7, 0));
    ops.push_back(mk(OP_S, 3'd2, 32'h60, 32'hCAFEBABE, 32'h0, 20, 0));
    ops.push_back(mk(OP_S, 3'd2, 32'h63, 32'hFEEDFACE, 32'h0, 0, 0));
    for (int i = 0; i < 40; i++) begin
      o.op = ($urandom_range(0, 1) == 1) ? OP_L : OP_S;
      o.f3 = (o.op == OP_L) ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      o.addr = $urandom(); o.sd = $urandom(); o.rdat = $urandom();
      o.gd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3);
      o.rd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3);
      ops.push_back(o);
    end
    for (int k = 0; k < ops.size(); k++) begin
      o = ops[k];
      run_op(o, stalls, reqs, q_addr, q_be, q_wdata, q_we, got_done, got_err, q_rdata, req_in_done);
      is_ld = (o.op == OP_L);
      nb = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
      base = (int'(o.addr[1:0]) / nb) * nb;
      for (int i = 0; i < 4; i++) begin
        e_be[i] = (i >= base) && (i < base + nb);
        e_wd[8*i +: 8] = o.sd[8*(i % nb) +: 8];
      end
      mis = MIS_CHK && ((int'(o.addr[1:0]) % nb) != 0);
      g = o.gd + 1;
      if (mis) begin
        e_req = 0; e_err = 1'b1; e_st = 1;
      end else if (!is_ld) begin
        e_err = (g > T); e_req = e_err ? T : g; e_st = 1 + e_req;
      end else if (g > T) begin
        e_err = 1'b1; e_req = T; e_st = 1 + T;
      end else begin
        lim = (g + 1 > T) ? g + 1 : T;
        r = g + o.rd + 1;
        e_err = (r > lim); e_req = g; e_st = 1 + (e_err ? lim : r);
      end
      if (!mis && is_ld) exp_rdata = e_err ? 32'h0 : o.rdat;
      n_chk++; if (got_done !== 1'b1) $display("FAIL acc%0d_done got %b want 1", k, got_done); else n_pass++;
      n_chk++; if (got_err !== e_err) $display("FAIL acc%0d_err got %b want %b", k, got_err, e_err); else n_pass++;
      n_chk++; if (stalls != e_st) $display("FAIL acc%0d_stalls got %0d want %0d", k, stalls, e_st); else n_pass++;
      n_chk++; if (reqs != e_req) $display("FAIL acc%0d_reqs got %0d want %0d", k, reqs, e_req); else n_pass++;
      n_chk++; if (q_rdata !== exp_rdata) $display("FAIL acc%0d_rdata got %h want %h", k, q_rdata, exp_rdata); else n_pass++;
      n_chk++; if (req_in_done !== 1'b0) $display("FAIL acc%0d_req_in_done got %b want 0", k, req_in_done); else n_pass++;
      if (e_req > 0) begin
        n_chk++; if (q_addr !== {o.addr[31:2], 2'b00}) $display("FAIL acc%0d_addr got %h want %h", k, q_addr, {o.addr[31:2], 2'b00}); else n_pass++;
        n_chk++; if (q_be !== e_be) $display("FAIL acc%0d_be got %b want %b", k, q_be, e_be); else n_pass++;
        n_chk++; if (q_we !== !is_ld) $display("FAIL acc%0d_we got %b want %b", k, q_we, !is_ld); else n_pass++;
        if (!is_ld) begin
          n_chk++; if (q_wdata !== e_wd) $display("FAIL acc%0d_wdata got %h want %h", k, q_wdata, e_wd); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_flush;
    inst_i = {17'd0, 3'd2, 5'd0, OP_L}; mem_addr_i = 32'h80; req_valid_i = 1'b1; flush_i = 1'b1;
    #1;
    n_chk++; if (stall_o !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall_o); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (bus.bus_req_o !== 1'b0) $display("FAIL flush_idle_req got %b want 0", bus.bus_req_o); else n_pass++;
    flush_i = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (bus.bus_req_o !== 1'b1) $display("FAIL flush_req_entry got %b want 1", bus.bus_req_o); else n_pass++;
    flush_i = 1'b1; req_valid_i = 1'b0;
    @(negedge clk); #1;
    n_chk++; if ({bus.bus_req_o, done_o, stall_o} !== 3'b000) $display("FAIL flush_req_abort got %b want 000", {bus.bus_req_o, done_o, stall_o}); else n_pass++;
    flush_i = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (done_o !== 1'b0) $display("FAIL flush_no_done got %b want 0", done_o); else n_pass++;
    inst_i = {17'd0, 3'd2, 5'd0, OP_S}; req_valid_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b1; flush_i = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (done_o !== 1'b1) $display("FAIL gnt_over_flush got %b want 1", done_o); else n_pass++;
    bus.bus_gnt_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk);
    inst_i = {17'd0, 3'd2, 5'd0, OP_L}; req_valid_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b0; flush_i = 1'b1; bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'h5A5AC3C3;
    @(negedge clk);
    bus.bus_rvalid_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0;
    #1;
    exp_rdata = 32'h5A5AC3C3;
    n_chk++; if ({done_o, stall_o} !== 2'b10) $display("FAIL flush_wait_done got %b want 10", {done_o, stall_o}); else n_pass++;
    n_chk++; if (rdata_o !== exp_rdata) $display("FAIL flush_wait_rdata got %h want %h", rdata_o, exp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    inst_i = {17'd0, 3'd2, 5'd0, OP_L}; mem_addr_i = 32'h84; req_valid_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b1;
    @(negedge clk);
    bus.bus_gnt_i = 1'b0; rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0; req_valid_i = 1'b0;
    #1;
    exp_rdata = 32'h0;
    n_chk++; if (bus.bus_req_o !== 1'b0) $display("FAIL rstmid_req got %b want 0", bus.bus_req_o); else n_pass++;
    bus.bus_rvalid_i = 1'b1; bus.bus_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    bus.bus_rvalid_i = 1'b0;
    #1;
    n_chk++; if (rdata_o !== exp_rdata) $display("FAIL rstmid_rdata got %h want %h", rdata_o, exp_rdata); else n_pass++;
    n_chk++; if ({done_o, stall_o, err_o} !== 3'b000) $display("FAIL rstmid_flags got %b want 000", {done_o, stall_o, err_o}); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; inst_i = '0; mem_addr_i = '0; st_data_i = '0;
    bus.bus_gnt_i = 1'b0; bus.bus_rvalid_i = 1'b0; bus.bus_rdata_i = '0; exp_rdata = '0;
    test_reset;
    test_non_mem;
    test_accesses;
    test_flush;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
